// File: rtl/seq_gf_mult.sv
// seq_gf_mult: sequential digit-serial multiplier.
//   mode 0: unsigned integer product a*b (2W bits)
//   mode 1: carry-less GF(2)[x] product, optionally reduced mod P = x^W + poly
// The multiplier b is consumed MSB-first, DIGIT_BITS bits per clock, so a
// request takes D = DATA_WIDTH/DIGIT_BITS cycles in CALC plus a DONE handshake.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_valid / in_ready         operand request handshake (ready only in IDLE)
//   in_mode, in_reduce, in_poly operation select and reduction polynomial
//   in_mult_a, in_mult_b        multiplicand, multiplier
//   out_valid / out_ready       result handshake (valid only in DONE)
//   out_mult_result             2W-bit result, updated only on entry to DONE
//   busy                        high while in CALC or DONE
module seq_gf_mult #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DIGIT_BITS = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_mode,
    input  logic                        in_reduce,
    input  logic [DATA_WIDTH-1:0]       in_poly,
    input  logic [DATA_WIDTH-1:0]       in_mult_a,
    input  logic [DATA_WIDTH-1:0]       in_mult_b,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [2*DATA_WIDTH-1:0]     out_mult_result,
    output logic                        busy
);

    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned K     = DIGIT_BITS;
    localparam int unsigned D     = W / K;
    localparam int unsigned AW    = 2 * W;
    localparam int unsigned CNT_W = (D > 1) ? $clog2(D) : 1;
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(D - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [AW-1:0]    acc;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic [W-1:0]     poly_reg;
    logic             mode_reg;
    logic             reduce_reg;

    logic [K-1:0]     digit;
    logic [AW-1:0]    partial;
    logic [AW-1:0]    shifted;
    logic [AW-1:0]    acc_next;

    // b_reg shifts left each CALC cycle, so the current digit is always on top
    assign digit = b_reg[W-1 -: K];

    // One digit step: shift accumulator, add/XOR a*digit, optionally reduce
    always_comb begin
        partial = '0;
        for (int unsigned j = 0; j < K; j++) begin
            if (digit[j]) begin
                if (mode_reg) begin
                    partial = partial ^ (AW'(a_reg) << j);
                end else begin
                    partial = partial + (AW'(a_reg) << j);
                end
            end
        end
        shifted  = acc << K;
        acc_next = mode_reg ? (shifted ^ partial) : (shifted + partial);
        // acc < 2^W before the step, so only bits W..W+K-1 can be set above
        // the field; clear them top-down by folding in shifted copies of P
        if (mode_reg && reduce_reg) begin
            for (int unsigned j = 0; j < K; j++) begin
                if (acc_next[W + K - 1 - j]) begin
                    acc_next = acc_next ^ (AW'({1'b1, poly_reg}) << (K - 1 - j));
                end
            end
        end
    end

    // Control FSM, operand registers and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            acc             <= '0;
            a_reg           <= '0;
            b_reg           <= '0;
            poly_reg        <= '0;
            mode_reg        <= 1'b0;
            reduce_reg      <= 1'b0;
            out_mult_result <= '0;
            out_valid       <= 1'b0;
            busy            <= 1'b0;
            in_ready        <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg      <= in_mult_a;
                        b_reg      <= in_mult_b;
                        poly_reg   <= in_poly;
                        mode_reg   <= in_mode;
                        // reduction only has meaning for carry-less products
                        reduce_reg <= in_mode & in_reduce;
                        acc        <= '0;
                        cnt        <= '0;
                        state      <= CALC;
                        in_ready   <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    b_reg <= b_reg << K;
                    if (cnt == LAST_DIGIT) begin
                        state           <= DONE;
                        out_valid       <= 1'b1;
                        out_mult_result <= acc_next;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_gf_mult.sv
// tb_seq_gf_mult: self-checking bench for seq_gf_mult.
// Three instances (W=8/K=1, W=8/K=4, W=32/K=1) share operand inputs and
// have private in_valid lines; results are compared against a polynomial-
// arithmetic reference model and hand-computed literals.
module tb_seq_gf_mult;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  iv;
    logic [2:0]  rdy;
    logic [2:0]  ov;
    logic [2:0]  bsy;
    logic        mode;
    logic        reduce;
    logic        out_ready;
    logic [31:0] poly;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [15:0] res_a;
    logic [15:0] res_b;
    logic [63:0] res_c;

    int          checks = 0;
    int          failures = 0;
    bit          mon_en = 1'b0;
    logic [63:0] exp_res [3];

    always #5 clk = ~clk;

    seq_gf_mult #(.DATA_WIDTH(8), .DIGIT_BITS(1)) u_w8k1 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(rdy[0]),
        .in_mode(mode), .in_reduce(reduce), .in_poly(poly[7:0]),
        .in_mult_a(op_a[7:0]), .in_mult_b(op_b[7:0]), .out_valid(ov[0]),
        .out_ready(out_ready), .out_mult_result(res_a), .busy(bsy[0])
    );

    seq_gf_mult #(.DATA_WIDTH(8), .DIGIT_BITS(4)) u_w8k4 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(rdy[1]),
        .in_mode(mode), .in_reduce(reduce), .in_poly(poly[7:0]),
        .in_mult_a(op_a[7:0]), .in_mult_b(op_b[7:0]), .out_valid(ov[1]),
        .out_ready(out_ready), .out_mult_result(res_b), .busy(bsy[1])
    );

    seq_gf_mult #(.DATA_WIDTH(32), .DIGIT_BITS(1)) u_w32k1 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(rdy[2]),
        .in_mode(mode), .in_reduce(reduce), .in_poly(poly),
        .in_mult_a(op_a), .in_mult_b(op_b), .out_valid(ov[2]),
        .out_ready(out_ready), .out_mult_result(res_c), .busy(bsy[2])
    );

    // ---------------- reference model ----------------
    function automatic logic [63:0] clmul(input logic [31:0] a, input logic [31:0] b, input int w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            if (b[i]) r = r ^ (64'(a) << i);
        end
        return r;
    endfunction

    function automatic logic [63:0] polymod(input logic [63:0] x, input logic [31:0] p, input int w);
        logic [64:0] pf;
        pf = (65'(1) << w) | 65'(p);
        for (int i = 2 * w - 2; i >= w; i--) begin
            if (x[i]) x = x ^ 64'(pf << (i - w));
        end
        return x;
    endfunction

    function automatic logic [63:0] model(input logic m, input logic r, input logic [31:0] p,
                                          input logic [31:0] a, input logic [31:0] b, input int w);
        if (!m) return 64'(a) * 64'(b);
        if (r) return polymod(clmul(a, b, w), p, w);
        return clmul(a, b, w);
    endfunction

    // ---------------- checking helpers ----------------
    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endfunction

    function automatic logic [63:0] res_of(input int inst);
        case (inst)
            0:       return 64'(res_a);
            1:       return 64'(res_b);
            default: return res_c;
        endcase
    endfunction

    // Continuous invariants and result check whenever out_valid is high
    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 3; i++) begin
                check("mon ready_vs_busy", {63'b0, rdy[i]}, {63'b0, ~bsy[i]});
                if (ov[i] === 1'b1) begin
                    check("mon busy_in_done", {63'b0, bsy[i]}, 64'd1);
                    check("mon result", res_of(i), exp_res[i]);
                end
            end
        end
    end

    task automatic start_op(input int inst, input logic m, input logic r, input logic [31:0] p,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] exp, input string name);
        int waited;
        waited = 0;
        @(negedge clk);
        while (rdy[inst] !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check({name, " ready"}, {63'b0, rdy[inst]}, 64'd1);
        exp_res[inst] = exp;
        mode   = m;
        reduce = r;
        poly   = p;
        op_a   = a;
        op_b   = b;
        iv[inst] = 1'b1;
        @(posedge clk);
        #1;
        iv[inst] = 1'b0;
    endtask

    task automatic wait_done(input int inst, input logic [63:0] exp, input int exp_lat,
                             input string name, input bit noise);
        int lat;
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            if (noise && i == 2) begin
                iv[inst] = 1'b1;
                op_a = $urandom;
                op_b = $urandom;
                poly = $urandom;
                mode = ~mode;
            end
            @(posedge clk);
            #1;
            if (ov[inst] === 1'b1) begin
                lat = i;
                break;
            end
        end
        iv[inst] = 1'b0;
        check({name, " out_valid"}, {63'b0, ov[inst]}, 64'd1);
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " result"}, res_of(inst), exp);
    endtask

    task automatic finish_op(input int inst, input logic [63:0] exp, input int stall, input string name);
        repeat (stall) begin
            @(posedge clk);
            #1;
            check({name, " hold valid"}, {63'b0, ov[inst]}, 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, " release"}, {63'b0, ov[inst]}, 64'd0);
        check({name, " idle ready"}, {63'b0, rdy[inst]}, 64'd1);
        check({name, " result held"}, res_of(inst), exp);
    endtask

    task automatic run_op(input int inst, input logic m, input logic r, input logic [31:0] p,
                          input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp,
                          input int exp_lat, input string name, input bit noise, input int stall);
        start_op(inst, m, r, p, a, b, exp, name);
        wait_done(inst, exp, exp_lat, name, noise);
        finish_op(inst, exp, stall, name);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          rand_pass;
        int          f0;
        logic        m;
        logic        r;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] p;
        logic [63:0] e;

        rst       = 1'b1;
        iv        = '0;
        out_ready = 1'b0;
        mode      = 1'b0;
        reduce    = 1'b0;
        poly      = '0;
        op_a      = '0;
        op_b      = '0;
        for (int i = 0; i < 3; i++) exp_res[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        for (int i = 0; i < 3; i++) begin
            check("reset in_ready", {63'b0, rdy[i]}, 64'd1);
            check("reset out_valid", {63'b0, ov[i]}, 64'd0);
            check("reset busy", {63'b0, bsy[i]}, 64'd0);
            check("reset result", res_of(i), 64'd0);
        end
        mon_en = 1'b1;

        // pin the reference model to hand-computed values
        check("model mul8", model(1'b0, 1'b0, 32'h0, 32'hFF, 32'hFF, 8), 64'hFE01);
        check("model clmul8", model(1'b1, 1'b0, 32'h0, 32'h57, 32'h83, 8), 64'h2B79);
        check("model gf8", model(1'b1, 1'b1, 32'h1B, 32'h57, 32'h83, 8), 64'h00C1);
        check("model mul32", model(1'b0, 1'b0, 32'h0, 32'h0000FFFF, 32'h00010001, 32), 64'hFFFFFFFF);

        // directed cases
        run_op(0, 1'b0, 1'b0, 32'h00, 32'hFF, 32'hFF, 64'hFE01, 8, "w8k1 mul", 1'b0, 0);
        run_op(0, 1'b1, 1'b0, 32'h00, 32'h57, 32'h83, 64'h2B79, 8, "w8k1 clmul", 1'b0, 0);
        run_op(0, 1'b1, 1'b1, 32'h1B, 32'h57, 32'h83, 64'h00C1, 8, "w8k1 gf", 1'b0, 0);
        run_op(1, 1'b1, 1'b1, 32'h1B, 32'h57, 32'h83, 64'h00C1, 2, "w8k4 gf", 1'b0, 0);
        run_op(1, 1'b0, 1'b1, 32'h1B, 32'hFF, 32'hFF, 64'hFE01, 2, "w8k4 mul reduce_ignored", 1'b0, 1);
        run_op(1, 1'b1, 1'b0, 32'h00, 32'h57, 32'h83, 64'h2B79, 2, "w8k4 clmul", 1'b1, 0);
        run_op(0, 1'b1, 1'b1, 32'h00, 32'h57, 32'h83, 64'h0079, 8, "w8k1 poly0", 1'b0, 0);
        run_op(0, 1'b1, 1'b1, 32'h1B, 32'h00, 32'h83, 64'h0000, 8, "w8k1 zero", 1'b0, 0);
        run_op(0, 1'b0, 1'b0, 32'h00, 32'hA5, 32'h00, 64'h0000, 8, "w8k1 zero mul", 1'b0, 0);

        // DONE stall with out_ready low and a competing request
        start_op(0, 1'b1, 1'b0, 32'h00, 32'h57, 32'h83, 64'h2B79, "stall");
        wait_done(0, 64'h2B79, 8, "stall", 1'b0);
        iv[0] = 1'b1;
        op_a  = 32'h12;
        op_b  = 32'h34;
        mode  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall out_valid", {63'b0, ov[0]}, 64'd1);
            check("stall result", res_of(0), 64'h2B79);
            check("stall in_ready", {63'b0, rdy[0]}, 64'd0);
        end
        iv[0]     = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("stall release", {63'b0, ov[0]}, 64'd0);
        check("stall idle ready", {63'b0, rdy[0]}, 64'd1);
        check("stall result held", res_of(0), 64'h2B79);
        repeat (3) @(posedge clk);
        #1;
        check("stall not queued", {63'b0, bsy[0]}, 64'd0);

        // randomized W=32 requests, 200 per mode
        rand_pass = 0;
        for (int n = 0; n < 400; n++) begin
            m = (n >= 200) ? 1'b1 : 1'b0;
            r = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            p = $urandom;
            case ($urandom_range(0, 9))
                0: a = '0;
                1: b = '0;
                2: p = '0;
                3: a = '1;
                4: b = '1;
                default: ;
            endcase
            e  = model(m, r, p, a, b, 32);
            f0 = failures;
            run_op(2, m, r, p, a, b, e, 32, "rand32", (n % 5) == 0, int'($urandom_range(0, 3)));
            if (failures == f0) rand_pass++;
        end
        $display("random requests passed=%0d of 400", rand_pass);

        // reset mid-CALC aborts and clears, then a fresh request works
        start_op(2, 1'b0, 1'b0, 32'h0, 32'hDEADBEEF, 32'hCAFEF00D, 64'hDEADBEEF * 64'hCAFEF00D, "abort");
        repeat (10) @(posedge clk);
        #1;
        check("abort busy mid_calc", {63'b0, bsy[2]}, 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort out_valid", {63'b0, ov[2]}, 64'd0);
        check("abort busy", {63'b0, bsy[2]}, 64'd0);
        check("abort result", res_c, 64'd0);
        check("abort in_ready", {63'b0, rdy[2]}, 64'd1);
        repeat (40) @(posedge clk);
        #1;
        check("abort discarded", {63'b0, ov[2]}, 64'd0);
        run_op(2, 1'b0, 1'b0, 32'h0, 32'h0000FFFF, 32'h00010001, 64'h00000000FFFFFFFF, 32,
               "post_reset", 1'b0, 0);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
